// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, main memory and mem_arbiter.
// slave  : the arbiter's view (takes cache requests, drives memory commands).
// master : the surrounding system's view (caches and memory together).
interface mem_arbiter_if;
  logic         I_MEM_READ;
  logic [27:0]  I_MEM_ADDRESS;
  logic [127:0] I_MEM_READDATA;
  logic         I_MEM_BUSYWAIT;
  logic         D_MEM_READ;
  logic         D_MEM_WRITE;
  logic [27:0]  D_MEM_ADDRESS;
  logic [127:0] D_MEM_WRITEDATA;
  logic [127:0] D_MEM_READDATA;
  logic         D_MEM_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  I_MEM_READ, I_MEM_ADDRESS,
    input  D_MEM_READ, D_MEM_WRITE, D_MEM_ADDRESS, D_MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output I_MEM_READDATA, I_MEM_BUSYWAIT,
    output D_MEM_READDATA, D_MEM_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output I_MEM_READ, I_MEM_ADDRESS,
    output D_MEM_READ, D_MEM_WRITE, D_MEM_ADDRESS, D_MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  I_MEM_READDATA, I_MEM_BUSYWAIT,
    input  D_MEM_READDATA, D_MEM_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single 128-bit block memory port between the icache
// (read refills) and the dcache (refills and write-backs). The granted command
// is latched so memory sees it stable for the whole transaction.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ties between the caches using a
// LAST_OWNER register; when undefined the dcache always wins a tie.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_arbiter_if.slave      bus,
  output logic [1:0]        GRANT,
  output logic              TIMEOUT_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_e;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;    // 0 = icache, 1 = dcache
  logic             op_wr_q, op_wr_d;
  logic [27:0]      addr_q, addr_d;
  logic [127:0]     wdata_q, wdata_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
  logic             i_req, d_req, pick_dcache, active, done;
`ifdef ARB_ROUND_ROBIN_EN
  logic             last_owner_q, last_owner_d;
`endif

  // Request decode and tie-break between the two caches.
  always_comb begin
    i_req       = bus.I_MEM_READ;
    d_req       = bus.D_MEM_READ | bus.D_MEM_WRITE;
    pick_dcache = d_req;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_dcache = ~last_owner_q;
`else
      pick_dcache = 1'b1;
`endif
    end
  end

  // Next-state, command latches and watchdog.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d   = S_ISSUE;
          owner_d   = pick_dcache;
          tmo_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = pick_dcache;
`endif
          if (pick_dcache) begin
            // READ and WRITE together is illegal; WRITE takes precedence.
            op_wr_d = bus.D_MEM_WRITE;
            addr_d  = bus.D_MEM_ADDRESS;
            wdata_d = bus.D_MEM_WRITE ? bus.D_MEM_WRITEDATA : '0;
          end else begin
            op_wr_d = 1'b0;
            addr_d  = bus.I_MEM_ADDRESS;
            wdata_d = '0;
          end
        end
      end
      S_ISSUE:   if (bus.MEM_BUSYWAIT) state_d = S_WAIT;
      S_WAIT:    if (!bus.MEM_BUSYWAIT) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (active) begin
      if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (TIMEOUT_CYCLES != 0 && tmo_cnt_d == TMO_LIM) tmo_err_d = 1'b1;
    end
  end

  // State and latches; RESET clears everything without waiting for a clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Memory commands, grant and per-cache stalls.
  always_comb begin
    active             = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done               = (state_q == S_WAIT) && !bus.MEM_BUSYWAIT;
    bus.MEM_READ       = active & ~op_wr_q;
    bus.MEM_WRITE      = active & op_wr_q;
    bus.MEM_ADDRESS    = active ? addr_q : '0;
    bus.MEM_WRITEDATA  = active ? wdata_q : '0;
    GRANT              = active ? {owner_q, ~owner_q} : 2'b00;
    // A pending non-owner stays stalled even in the owner's completion cycle.
    bus.I_MEM_BUSYWAIT = i_req & ~(done & ~owner_q);
    bus.D_MEM_BUSYWAIT = d_req & ~(done & owner_q);
    bus.I_MEM_READDATA = bus.MEM_READDATA;
    bus.D_MEM_READDATA = bus.MEM_READDATA;
    TIMEOUT_ERR        = tmo_err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, tie, back-to-back
// dcache traffic, watchdog and reset during a transaction.
module tb_mem_arbiter;
  logic       CLK;
  logic       RESET;
  logic [1:0] GRANT;
  logic       TIMEOUT_ERR;
  int         n_chk;
  int         n_fail;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYCLES(255), .TMO_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the ISSUE cycle; returns in the completion cycle.
  task automatic run_txn(input string tag, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wdata, input logic [1:0] grant,
                         input int busy_n, input logic [127:0] rdata);
    chk({tag, ":rd"}, bus.MEM_READ, !wr);
    chk({tag, ":wr"}, bus.MEM_WRITE, wr);
    chk({tag, ":addr"}, bus.MEM_ADDRESS, addr);
    chk({tag, ":wdata"}, bus.MEM_WRITEDATA, wdata);
    chk({tag, ":grant"}, GRANT, grant);
    bus.MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < busy_n; i++) begin
      @(negedge CLK);
      chk({tag, ":hold_addr"}, bus.MEM_ADDRESS, addr);
      chk({tag, ":hold_grant"}, GRANT, grant);
      chk({tag, ":own_bw"}, grant[1] ? bus.D_MEM_BUSYWAIT : bus.I_MEM_BUSYWAIT, 1'b1);
    end
    bus.MEM_BUSYWAIT = 1'b0;
    bus.MEM_READDATA = rdata;
    #1;
    chk({tag, ":own_bw_done"}, grant[1] ? bus.D_MEM_BUSYWAIT : bus.I_MEM_BUSYWAIT, 1'b0);
    chk({tag, ":rdata"}, grant[1] ? bus.D_MEM_READDATA : bus.I_MEM_READDATA, rdata);
    if (grant[1]) chk({tag, ":other_bw"}, bus.I_MEM_BUSYWAIT, bus.I_MEM_READ);
    else          chk({tag, ":other_bw"}, bus.D_MEM_BUSYWAIT, bus.D_MEM_READ | bus.D_MEM_WRITE);
  endtask

  // Advance to the RELEASE cycle and check the bus is quiet.
  task automatic release_chk(input string tag);
    @(negedge CLK);
    chk({tag, ":rel_rd"}, bus.MEM_READ, 1'b0);
    chk({tag, ":rel_wr"}, bus.MEM_WRITE, 1'b0);
    chk({tag, ":rel_grant"}, GRANT, 2'b00);
  endtask

  initial begin
    logic [127:0] pat_a5;
    logic [127:0] pat_wb;
    n_chk  = 0;
    n_fail = 0;
    pat_a5 = {16{8'hA5}};
    pat_wb = {4{32'h1234_5678}};
    RESET = 1'b1;
    bus.I_MEM_READ = 0; bus.I_MEM_ADDRESS = '0;
    bus.D_MEM_READ = 0; bus.D_MEM_WRITE = 0; bus.D_MEM_ADDRESS = '0; bus.D_MEM_WRITEDATA = '0;
    bus.MEM_READDATA = '0; bus.MEM_BUSYWAIT = 0;
    @(negedge CLK);
    RESET = 1'b0;

    // 1: random traffic, then asynchronous reset mid-cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      bus.I_MEM_READ    = 1'($urandom);
      bus.I_MEM_ADDRESS = 28'($urandom);
      bus.D_MEM_READ    = 1'($urandom);
      bus.D_MEM_WRITE   = 1'($urandom);
      bus.D_MEM_ADDRESS = 28'($urandom);
      bus.D_MEM_WRITEDATA = {4{32'($urandom)}};
      bus.MEM_BUSYWAIT  = 1'($urandom);
    end
    #2 RESET = 1'b1;
    #1;
    chk("rst:rd", bus.MEM_READ, 1'b0);
    chk("rst:wr", bus.MEM_WRITE, 1'b0);
    chk("rst:grant", GRANT, 2'b00);
    chk("rst:tmo", TIMEOUT_ERR, 1'b0);
    chk("rst:addr", bus.MEM_ADDRESS, 28'h0);
    chk("rst:wdata", bus.MEM_WRITEDATA, 128'h0);
    chk("rst:i_bw", bus.I_MEM_BUSYWAIT, bus.I_MEM_READ);
    chk("rst:d_bw", bus.D_MEM_BUSYWAIT, bus.D_MEM_READ | bus.D_MEM_WRITE);
    @(negedge CLK);
    chk("rst_hold:grant", GRANT, 2'b00);
    bus.I_MEM_READ = 0; bus.D_MEM_READ = 0; bus.D_MEM_WRITE = 0; bus.MEM_BUSYWAIT = 0;
    RESET = 1'b0;
    @(negedge CLK);

    // 2: single icache read, 5 busy cycles
    bus.I_MEM_READ = 1; bus.I_MEM_ADDRESS = 28'h0000123;
    #1;
    chk("t2:req_bw", bus.I_MEM_BUSYWAIT, 1'b1);
    chk("t2:lat_rd", bus.MEM_READ, 1'b0);
    @(negedge CLK);
    run_txn("t2", 1'b0, 28'h0000123, 128'h0, 2'b01, 5, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233);
    release_chk("t2");
    bus.I_MEM_READ = 0;
    @(negedge CLK);
    chk("t2:idle_grant", GRANT, 2'b00);

    // 3: tie, icache read vs dcache write -> dcache first
    bus.I_MEM_READ = 1; bus.I_MEM_ADDRESS = 28'h10;
    bus.D_MEM_WRITE = 1; bus.D_MEM_ADDRESS = 28'h20; bus.D_MEM_WRITEDATA = pat_a5;
    @(negedge CLK);
    run_txn("t3d", 1'b1, 28'h20, pat_a5, 2'b10, 3, 128'h0);
    release_chk("t3d");
    chk("t3:i_bw_rel", bus.I_MEM_BUSYWAIT, 1'b1);
    bus.D_MEM_WRITE = 0;
    @(negedge CLK);
    chk("t3:idle_grant", GRANT, 2'b00);
    chk("t3:i_bw_idle", bus.I_MEM_BUSYWAIT, 1'b1);
    @(negedge CLK);
    run_txn("t3i", 1'b0, 28'h10, 128'h0, 2'b01, 2, 128'h5555);
    release_chk("t3i");
    bus.I_MEM_READ = 0;
    @(negedge CLK);

    // 4: dcache write-back, then dcache read while icache still pending
    bus.I_MEM_READ = 1; bus.I_MEM_ADDRESS = 28'h30;
    bus.D_MEM_WRITE = 1; bus.D_MEM_ADDRESS = 28'h40; bus.D_MEM_WRITEDATA = pat_wb;
    @(negedge CLK);
    run_txn("t4wb", 1'b1, 28'h40, pat_wb, 2'b10, 2, 128'h0);
    release_chk("t4wb");
    bus.D_MEM_WRITE = 0; bus.D_MEM_READ = 1; bus.D_MEM_ADDRESS = 28'h50;
    @(negedge CLK);
    chk("t4:idle_grant", GRANT, 2'b00);
    @(negedge CLK);
`ifdef ARB_ROUND_ROBIN_EN
    run_txn("t4i", 1'b0, 28'h30, 128'h0, 2'b01, 1, 128'h3030);
    release_chk("t4i");
    bus.I_MEM_READ = 0;
    @(negedge CLK);
    @(negedge CLK);
    run_txn("t4d", 1'b0, 28'h50, 128'h0, 2'b10, 1, 128'h5050);
    release_chk("t4d");
    bus.D_MEM_READ = 0;
`else
    run_txn("t4d", 1'b0, 28'h50, 128'h0, 2'b10, 1, 128'h5050);
    release_chk("t4d");
    bus.D_MEM_READ = 0;
    @(negedge CLK);
    @(negedge CLK);
    run_txn("t4i", 1'b0, 28'h30, 128'h0, 2'b01, 1, 128'h3030);
    release_chk("t4i");
    bus.I_MEM_READ = 0;
`endif
    @(negedge CLK);

    // 5: watchdog, memory busy for 300 cycles
    bus.D_MEM_READ = 1; bus.D_MEM_ADDRESS = 28'h77;
    @(negedge CLK);
    chk("t5:rd", bus.MEM_READ, 1'b1);
    chk("t5:grant", GRANT, 2'b10);
    chk("t5:tmo_start", TIMEOUT_ERR, 1'b0);
    bus.MEM_BUSYWAIT = 1;
    for (int n = 2; n <= 301; n++) begin
      @(negedge CLK);
      if (n == 255) chk("t5:tmo_before", TIMEOUT_ERR, 1'b0);
      if (n == 256) chk("t5:tmo_rise", TIMEOUT_ERR, 1'b1);
      if (n == 301) begin
        chk("t5:tmo_hold", TIMEOUT_ERR, 1'b1);
        chk("t5:d_bw", bus.D_MEM_BUSYWAIT, 1'b1);
        chk("t5:addr", bus.MEM_ADDRESS, 28'h77);
      end
    end
    bus.MEM_BUSYWAIT = 0; bus.MEM_READDATA = 128'h7777_0000_7777;
    #1;
    chk("t5:d_bw_done", bus.D_MEM_BUSYWAIT, 1'b0);
    chk("t5:rdata", bus.D_MEM_READDATA, 128'h7777_0000_7777);
    release_chk("t5");
    bus.D_MEM_READ = 0;
    @(negedge CLK);
    chk("t5:tmo_sticky", TIMEOUT_ERR, 1'b1);

    // 6: reset during WAIT, then normal reissue
    bus.I_MEM_READ = 1; bus.I_MEM_ADDRESS = 28'h99;
    @(negedge CLK);
    bus.MEM_BUSYWAIT = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("t6:wait_rd", bus.MEM_READ, 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("t6:rst_rd", bus.MEM_READ, 1'b0);
    chk("t6:rst_grant", GRANT, 2'b00);
    chk("t6:rst_addr", bus.MEM_ADDRESS, 28'h0);
    chk("t6:rst_tmo", TIMEOUT_ERR, 1'b0);
    chk("t6:rst_i_bw", bus.I_MEM_BUSYWAIT, 1'b1);
    @(negedge CLK);
    bus.MEM_BUSYWAIT = 0;
    RESET = 1'b0;
    @(negedge CLK);
    run_txn("t6", 1'b0, 28'h99, 128'h0, 2'b01, 1, 128'h9999);
    release_chk("t6");
    bus.I_MEM_READ = 0;
    @(negedge CLK);
    chk("t6:idle_grant", GRANT, 2'b00);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
